posit_norm_adjust: RTL

- Parametrised normalisation stage for the posit multiply datapath. Takes the raw mantissa product and the running scale, and shifts the mantissa until its top two bits are 01. It then splits the adjusted scale into sign, regime and exponent fields.
- Improves on the fixed 64-bit stage in four ways: configurable width and ES, multi-bit left shifts per cycle, explicit zero detection (no hang on an all-zero product), and scale saturation.
- Uses valid/ready handshakes on both sides. Sits between the mantissa multiplier and the posit encoder.

---
 rtl/posit_norm_adjust_if.sv | 36 +++
 rtl/posit_norm_adjust.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/posit_norm_adjust_if.sv
// Handshake and data bundle for the posit normalisation stage.
// The master side feeds operands and accepts results; the slave side is the stage.
interface posit_norm_adjust_if #(
  parameter int MANT_W  = 64,
  parameter int SCALE_W = 10,
  parameter int ES      = 3,
  parameter int SA_W    = $clog2(MANT_W) + 1
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic signed [SCALE_W-1:0] scale_in;
  logic [MANT_W-1:0]         mant_in;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [SCALE_W-1:0] scale_out;
  logic [MANT_W-1:0]         mant_out;
  logic [SA_W-1:0]           shift_amt;
  logic                      shift_dir;
  logic [ES-1:0]             adj_exp;
  logic [SCALE_W-ES-2:0]     adj_regime;
  logic                      exp_sign;
  logic                      is_zero;
  logic                      sat;

  modport master (
    output in_valid, scale_in, mant_in, out_ready,
    input  in_ready, out_valid, scale_out, mant_out, shift_amt, shift_dir,
           adj_exp, adj_regime, exp_sign, is_zero, sat
  );

  modport slave (
    input  in_valid, scale_in, mant_in, out_ready,
    output in_ready, out_valid, scale_out, mant_out, shift_amt, shift_dir,
           adj_exp, adj_regime, exp_sign, is_zero, sat
  );
endinterface

// File: rtl/posit_norm_adjust.sv
// Posit multiply normalisation: shifts the mantissa product until its top
// two bits are 01, tracks the scale with saturation, and splits the final
// scale into sign / regime / exponent fields.
module posit_norm_adjust #(
  parameter int MANT_W     = 64,
  parameter int SCALE_W    = 10,
  parameter int ES         = 3,
  parameter int SHIFT_STEP = 4,
  parameter int SA_W       = $clog2(MANT_W) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  posit_norm_adjust_if.slave  bus
);

  localparam int SW = SCALE_W + SA_W + 1;
  localparam logic signed [SW-1:0] SMAX = SW'(2 ** (SCALE_W - 1) - 1);
  localparam logic signed [SW-1:0] SMIN = -(SW'(2 ** (SCALE_W - 1)));
  localparam logic [SA_W-1:0] STEP = SA_W'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t                    state_q, state_d;
  logic [MANT_W-1:0]         w_q, w_d;
  logic signed [SCALE_W-1:0] ws_q, ws_d;
  logic [SA_W-1:0]           cnt_q, cnt_d;
  logic                      dir_q, dir_d;
  logic                      wsat_q, wsat_d;
  logic [MANT_W-1:0]         mant_out_q, mant_out_d;
  logic signed [SCALE_W-1:0] scale_out_q, scale_out_d;
  logic [SA_W-1:0]           shift_amt_q, shift_amt_d;
  logic                      shift_dir_q, shift_dir_d;
  logic                      is_zero_q, is_zero_d;
  logic                      sat_q, sat_d;

  logic [SA_W-1:0]           lz, lm1, d;
  logic signed [SA_W:0]      delta;
  logic                      s_sat;
  logic signed [SCALE_W-1:0] s_new;

  // Count of leading zeros from the MSB; a zero word never reaches SHIFT.
  function automatic logic [SA_W-1:0] lzc(input logic [MANT_W-1:0] v);
    logic [SA_W-1:0] n;
    logic            done;
    n    = '0;
    done = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) done = 1'b1;
        else      n    = n + 1'b1;
      end
    end
    return n;
  endfunction

  // Signed add that clamps to the representable scale range; MSB flags a clamp.
  function automatic logic [SCALE_W:0] sat_add(input logic signed [SCALE_W-1:0] a,
                                               input logic signed [SA_W:0]      b);
    logic signed [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SMAX)      return {1'b1, SMAX[SCALE_W-1:0]};
    else if (s < SMIN) return {1'b1, SMIN[SCALE_W-1:0]};
    else               return {1'b0, s[SCALE_W-1:0]};
  endfunction

  // Shift distance and scale update for the current working mantissa.
  always_comb begin
    lz    = lzc(w_q);
    lm1   = lz - 1'b1;
    d     = (lm1 > STEP) ? STEP : lm1;
    delta = w_q[MANT_W-1] ? (SA_W+1)'(1) : -$signed({1'b0, d});
    {s_sat, s_new} = sat_add(ws_q, delta);
  end

  // Next-state and datapath updates for IDLE / SHIFT / OUT.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    ws_d        = ws_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    wsat_d      = wsat_q;
    mant_out_d  = mant_out_q;
    scale_out_d = scale_out_q;
    shift_amt_d = shift_amt_q;
    shift_dir_d = shift_dir_q;
    is_zero_d   = is_zero_q;
    sat_d       = sat_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          w_d    = bus.mant_in;
          ws_d   = bus.scale_in;
          cnt_d  = '0;
          dir_d  = 1'b0;
          wsat_d = 1'b0;
          if (bus.mant_in == '0) begin
            mant_out_d  = '0;
            scale_out_d = '0;
            shift_amt_d = '0;
            shift_dir_d = 1'b0;
            sat_d       = 1'b0;
            is_zero_d   = 1'b1;
            state_d     = OUT;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (w_q[MANT_W-1]) begin
          // Overflowed product: one right shift always lands on 01.
          w_d    = w_q >> 1;
          ws_d   = s_new;
          wsat_d = wsat_q | s_sat;
          cnt_d  = SA_W'(1);
          dir_d  = 1'b1;
        end else if (!w_q[MANT_W-2]) begin
          w_d    = w_q << d;
          ws_d   = s_new;
          wsat_d = wsat_q | s_sat;
          cnt_d  = cnt_q + d;
        end else begin
          mant_out_d  = w_q;
          scale_out_d = ws_q;
          shift_amt_d = cnt_q;
          shift_dir_d = dir_q;
          sat_d       = wsat_q;
          is_zero_d   = 1'b0;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working and output registers; reset discards any in-flight operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= '0;
      ws_q        <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      wsat_q      <= 1'b0;
      mant_out_q  <= '0;
      scale_out_q <= '0;
      shift_amt_q <= '0;
      shift_dir_q <= 1'b0;
      is_zero_q   <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      ws_q        <= ws_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      wsat_q      <= wsat_d;
      mant_out_q  <= mant_out_d;
      scale_out_q <= scale_out_d;
      shift_amt_q <= shift_amt_d;
      shift_dir_q <= shift_dir_d;
      is_zero_q   <= is_zero_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == OUT);
  assign bus.mant_out   = mant_out_q;
  assign bus.scale_out  = scale_out_q;
  assign bus.shift_amt  = shift_amt_q;
  assign bus.shift_dir  = shift_dir_q;
  assign bus.is_zero    = is_zero_q;
  assign bus.sat        = sat_q;
  assign bus.adj_exp    = scale_out_q[ES-1:0];
  assign bus.adj_regime = scale_out_q[SCALE_W-2:ES];
  assign bus.exp_sign   = scale_out_q[SCALE_W-1];

endmodule
